// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result bus between instruction decode and the ALU execution stage
//   master (decode side): drives start_valid, opcode, opa, opb, carry_in
//   slave  (ALU side)   : drives start_ready, dataa, carry, enaf, busy, illegal
interface alu_exec_if #(parameter int MAX_WIDTH = 8);
    logic                 start_valid;
    logic                 start_ready;
    logic [3:0]           opcode;
    logic [MAX_WIDTH-1:0] opa;
    logic [MAX_WIDTH-1:0] opb;
    logic                 carry_in;
    logic [MAX_WIDTH-1:0] dataa;
    logic                 carry;
    logic                 enaf;
    logic                 busy;
    logic                 illegal;
    modport master (
        output start_valid, opcode, opa, opb, carry_in,
        input  start_ready, dataa, carry, enaf, busy, illegal
    );
    modport slave (
        input  start_valid, opcode, opa, opb, carry_in,
        output start_ready, dataa, carry, enaf, busy, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU stage feeding the flag register (result, carry, enaf strobe)
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_exec_if.slave -- valid/ready request in, dataa/carry/enaf/busy/illegal out
//   Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 10);
//   otherwise opcode 10 is reported as illegal like 11-15.
module alu_exec_unit #(
    parameter int MAX_WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_exec_if.slave bus
);
    localparam int W = MAX_WIDTH;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t         state;
    logic [W-1:0]   a, b, dataa;
    logic [3:0]     op;
    logic [W:0]     sum, res;
    logic           carry, enaf, illegal, legal;
    assign a  = bus.opa;
    assign b  = bus.opb;
    assign op = bus.opcode;
    // ADD and ADC share one adder; carry_in only counts for ADC
    assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, op == 4'd1 && bus.carry_in};
    // bit W of every single-cycle result is the carry/borrow/shift-out
    assign res = (op == 4'd0 || op == 4'd1) ? sum :
                 op == 4'd2 ? {1'b0, a} - {1'b0, b} :
                 op == 4'd3 ? {1'b0, a & b} :
                 op == 4'd4 ? {1'b0, a | b} :
                 op == 4'd5 ? {1'b0, a ^ b} :
                 op == 4'd6 ? {1'b0, ~a} :
                 op == 4'd7 ? {a, 1'b0} :
                 op == 4'd8 ? {a[0], 1'b0, a[W-1:1]} :
                 op == 4'd9 ? {1'b0, b} : '0;
    assign legal = op <= 4'd9;
`ifdef ALU_MUL_EN
    localparam int IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);
    logic [2*W-1:0] acc, mcand, acc_n;
    logic [W-1:0]   mplier;
    logic [IW-1:0]  iter;
    assign acc_n = acc + (mplier[0] ? mcand : '0);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dataa   <= '0;
            carry   <= 1'b0;
            enaf    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            enaf    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (bus.start_valid) begin
`ifdef ALU_MUL_EN
                    if (op == 4'd10) begin
                        state  <= EXEC;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        iter   <= '0;
                    end else
`endif
                    if (legal) begin
                        state <= DONE;
                        dataa <= res[W-1:0];
                        carry <= res[W];
                        enaf  <= 1'b1;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
`ifdef ALU_MUL_EN
                EXEC: begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + 1'b1;
                    // the last partial product is folded in on the same edge the result is loaded
                    if (iter == ITER_LAST) begin
                        state <= DONE;
                        dataa <= acc_n[W-1:0];
                        carry <= |acc_n[2*W-1:W];
                        enaf  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.start_ready = state == IDLE;
    assign bus.busy        = state != IDLE;
    assign bus.dataa       = dataa;
    assign bus.carry       = carry;
    assign bus.enaf        = enaf;
    assign bus.illegal     = illegal;
endmodule
